// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto one memory port, single outstanding transaction.
// Latency: accept N, mem request N+1, earliest response N+2; backpressure via mem_req_ready, readies low while busy.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    input  logic              ifu_flush,
    output logic              ifu_resp_valid,
    output logic [DW-1:0]     ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_addr,
    input  logic              lsu_wen,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DW-1:0]     lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DW-1:0]     mem_rdata
);
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_owner;
    logic              owner;
    logic              drop;
    logic [AW-1:0]     addr_q;
    logic              wen_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wmask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the master that did not win last time gets the grant.
                ifu_req_ready = !rst && ifu_req_valid && (!lsu_req_valid || last_owner == OWN_LSU);
                lsu_req_ready = !rst && lsu_req_valid && (!ifu_req_valid || last_owner == OWN_IFU);
                if (ifu_req_ready || lsu_req_ready) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (mem_resp_valid) begin
                    ifu_resp_valid = (owner == OWN_IFU) && !drop;
                    lsu_resp_valid = (owner == OWN_LSU);
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_IFU;
            owner      <= OWN_IFU;
            drop       <= 1'b0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            if (lsu_req_ready) begin
                owner   <= OWN_LSU;
                drop    <= 1'b0;
                addr_q  <= lsu_addr;
                wen_q   <= lsu_wen;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else if (ifu_req_ready) begin
                owner   <= OWN_IFU;
                drop    <= 1'b0;
                addr_q  <= ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
            // A redirect mid-fetch lets memory finish but suppresses the IFU response.
            if (state != IDLE && owner == OWN_IFU && ifu_flush) drop <= 1'b1;
            if (state == RESP && mem_resp_valid) begin
                last_owner <= owner;
                drop       <= 1'b0;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed corner sequences, randomized traffic vs a transaction model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid, ifu_req_ready, ifu_flush, ifu_resp_valid;
    logic [AW-1:0]   ifu_addr;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_wdata, lsu_rdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_flush(ifu_flush), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_flush = 0; lsu_wen = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    // {ifu_v, lsu_v, mem_req_ready, mem_resp_valid, exp {ifu_rdy, lsu_rdy, mem_req_valid, ifu_resp, lsu_resp}}
    typedef struct packed {
        logic [3:0] in;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl [15];

    // reference model state
    logic        m_busy, m_taken, m_own, m_drop, m_last;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;
    int          n_exp_resp, n_seen_resp, pulses;
    logic        e_ifr, e_lsr, e_mrv, e_done, e_ifv, e_lsv;

    initial begin
        tbl[0]  = {4'b1010, 5'b10000};
        tbl[1]  = {4'b0010, 5'b00100};
        tbl[2]  = {4'b0001, 5'b00010};
        tbl[3]  = {4'b1110, 5'b01000};
        tbl[4]  = {4'b1110, 5'b00100};
        tbl[5]  = {4'b1101, 5'b00001};
        tbl[6]  = {4'b1110, 5'b10000};
        tbl[7]  = {4'b1110, 5'b00100};
        tbl[8]  = {4'b1101, 5'b00010};
        tbl[9]  = {4'b1100, 5'b01000};
        tbl[10] = {4'b0001, 5'b00100};
        tbl[11] = {4'b0010, 5'b00100};
        tbl[12] = {4'b0000, 5'b00000};
        tbl[13] = {4'b0001, 5'b00001};
        tbl[14] = {4'b0001, 5'b00000};

        // reset with requests pending
        rst = 1; ifu_req_valid = 1; lsu_req_valid = 1; ifu_flush = 0; mem_req_ready = 1;
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678; lsu_wen = 1;
        ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #12;
        chk1("rst_ifu_rdy", ifu_req_ready, 1'b0);
        chk1("rst_lsu_rdy", lsu_req_ready, 1'b0);
        chk1("rst_mem_vld", mem_req_valid, 1'b0);
        chk1("rst_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp", lsu_resp_valid, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        quiet();
        #1 rst = 0;

        // cycle vector table: IFU fetch, tie-break alternation, stall, strays
        for (int i = 0; i < 15; i++) begin
            cyc();
            {ifu_req_valid, lsu_req_valid, mem_req_ready, mem_resp_valid} = tbl[i].in;
            mem_rdata = 32'h1000 + i;
            @(negedge clk);
            chk32("tbl_outputs", {27'd0, ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid},
                  {27'd0, tbl[i].exp});
            chk32("tbl_rdata", ifu_rdata, 32'h1000 + i);
        end

        // single IFU fetch with minimum latency
        cyc(); quiet(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        @(negedge clk); chk1("fetch_accept", ifu_req_ready, 1'b1);
        cyc(); ifu_req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk1("fetch_mem_vld", mem_req_valid, 1'b1);
        chk32("fetch_mem_addr", mem_addr, 32'h8000_0000);
        chk1("fetch_mem_wen", mem_wen, 1'b0);
        chk32("fetch_mem_wmask", {28'd0, mem_wmask}, 32'h0);
        cyc(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        chk1("fetch_resp", ifu_resp_valid, 1'b1);
        chk32("fetch_rdata", ifu_rdata, 32'h0000_0413);
        chk1("fetch_no_lsu_resp", lsu_resp_valid, 1'b0);

        // LSU store with memory stalling three cycles
        cyc(); quiet(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clk); chk1("store_accept", lsu_req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); lsu_req_valid = 0; lsu_wdata = 32'h0; lsu_addr = 32'h0; lsu_wmask = 4'h0;
            mem_req_ready = (i == 3);
            @(negedge clk);
            chk1("store_mem_vld", mem_req_valid, 1'b1);
            chk32("store_addr", mem_addr, 32'h8000_1000);
            chk32("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk32("store_wmask", {28'd0, mem_wmask}, 32'hF);
            chk1("store_wen", mem_wen, 1'b1);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); mem_req_ready = 0; mem_resp_valid = (i != 1); mem_rdata = 32'hCAFE_0000 + i;
            @(negedge clk);
            if (lsu_resp_valid) pulses++;
            if (i == 0) chk32("store_rdata", lsu_rdata, 32'hCAFE_0000);
        end
        chk32("store_resp_pulses", pulses, 1);

        // flush while IFU fetch is outstanding
        cyc(); quiet(); ifu_req_valid = 1; ifu_flush = 1; ifu_addr = 32'h8000_0040;
        @(negedge clk); chk1("flush_same_cycle_accept", ifu_req_ready, 1'b1);
        cyc(); ifu_req_valid = 0; ifu_flush = 0; mem_req_ready = 1;
        @(negedge clk); chk1("flush_mem_vld", mem_req_valid, 1'b1);
        cyc(); mem_req_ready = 0; ifu_flush = 1;
        cyc(); ifu_flush = 0; mem_resp_valid = 1;
        @(negedge clk); chk1("flush_resp_dropped", ifu_resp_valid, 1'b0);
        cyc(); mem_resp_valid = 0; ifu_req_valid = 1;
        @(negedge clk); chk1("flush_next_accept", ifu_req_ready, 1'b1);
        cyc(); ifu_req_valid = 0; mem_req_ready = 1;
        cyc(); mem_req_ready = 0; mem_resp_valid = 1;
        @(negedge clk); chk1("flush_cleared_resp", ifu_resp_valid, 1'b1);

        // async reset between edges while waiting for response
        cyc(); quiet(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2000;
        lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'h3;
        cyc(); lsu_req_valid = 0; mem_req_ready = 1;
        cyc(); mem_req_ready = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        #2 rst = 1; mem_resp_valid = 1;
        #1;
        chk1("arst_mem_vld", mem_req_valid, 1'b0);
        chk1("arst_lsu_resp", lsu_resp_valid, 1'b0);
        chk1("arst_ifu_resp", ifu_resp_valid, 1'b0);
        chk1("arst_ifu_rdy", ifu_req_ready, 1'b0);
        chk1("arst_lsu_rdy", lsu_req_ready, 1'b0);
        chk32("arst_mem_addr", mem_addr, 32'h0);
        chk32("arst_mem_wdata", mem_wdata, 32'h0);
        chk32("arst_mem_wmask", {28'd0, mem_wmask}, 32'h0);
        chk1("arst_mem_wen", mem_wen, 1'b0);
        @(negedge clk);
        quiet();
        #1 rst = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(); mem_resp_valid = 1;
            @(negedge clk);
            chk1("post_rst_stray_lsu", lsu_resp_valid, 1'b0);
            chk1("post_rst_stray_ifu", ifu_resp_valid, 1'b0);
        end

        // randomized traffic against a transaction-level model
        m_busy = 0; m_taken = 0; m_own = 0; m_drop = 0; m_last = 0;
        m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0;
        n_exp_resp = 0; n_seen_resp = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (c < 2980) begin
                ifu_req_valid = 1'($urandom_range(0, 1));
                lsu_req_valid = 1'($urandom_range(0, 1));
                ifu_flush     = ($urandom_range(0, 7) == 0);
                mem_req_ready = ($urandom_range(0, 2) != 0);
                mem_resp_valid = (m_busy && m_taken) ? ($urandom_range(0, 2) != 0)
                                                     : ($urandom_range(0, 3) == 0);
            end else begin
                ifu_req_valid = 0; lsu_req_valid = 0; ifu_flush = 0;
                mem_req_ready = 1; mem_resp_valid = 1;
            end
            ifu_addr  = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
            lsu_wen   = 1'($urandom_range(0, 1)); lsu_wmask = 4'($urandom_range(0, 15));
            mem_rdata = $urandom;
            @(negedge clk);
            e_ifr  = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
            e_lsr  = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
            e_mrv  = m_busy && !m_taken;
            e_done = m_busy && m_taken && mem_resp_valid;
            e_ifv  = e_done && !m_own && !m_drop;
            e_lsv  = e_done && m_own;
            chk1("rnd_ifu_rdy", ifu_req_ready, e_ifr);
            chk1("rnd_lsu_rdy", lsu_req_ready, e_lsr);
            chk1("rnd_mem_vld", mem_req_valid, e_mrv);
            if (e_mrv) begin
                chk32("rnd_mem_addr", mem_addr, m_addr);
                chk32("rnd_mem_wdata", mem_wdata, m_wdata);
                chk32("rnd_mem_ctl", {27'd0, mem_wen, mem_wmask}, {27'd0, m_wen, m_wmask});
            end
            chk1("rnd_ifu_resp", ifu_resp_valid, e_ifv);
            chk1("rnd_lsu_resp", lsu_resp_valid, e_lsv);
            chk1("rnd_resp_overlap", ifu_resp_valid && lsu_resp_valid, 1'b0);
            if (e_ifv) chk32("rnd_ifu_rdata", ifu_rdata, mem_rdata);
            if (e_lsv) chk32("rnd_lsu_rdata", lsu_rdata, mem_rdata);
            if (e_ifv || e_lsv) n_exp_resp++;
            if (ifu_resp_valid || lsu_resp_valid) n_seen_resp++;
            if (e_done) begin
                m_busy = 0;
                m_last = m_own;
            end else if (m_busy) begin
                if (!m_taken && mem_req_ready) m_taken = 1;
                if (!m_own && ifu_flush) m_drop = 1;
            end else if (e_ifr || e_lsr) begin
                m_busy = 1; m_taken = 0; m_drop = 0; m_own = e_lsr;
                m_addr  = e_lsr ? lsu_addr : ifu_addr;
                m_wen   = e_lsr ? lsu_wen : 1'b0;
                m_wdata = e_lsr ? lsu_wdata : 32'h0;
                m_wmask = e_lsr ? lsu_wmask : 4'h0;
            end
        end
        chk1("rnd_drained", m_busy, 1'b0);
        chk32("rnd_resp_count", n_seen_resp, n_exp_resp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, reset.
REQ-004 IFU master ports SHALL be: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in AW; ifu_flush in 1 (branch redirect, discard in-flight fetch); ifu_resp_valid out 1; ifu_rdata out DW.
REQ-005 LSU master ports SHALL be: lsu_req_valid in 1; lsu_req_ready out 1; lsu_addr in AW; lsu_wen in 1; lsu_wdata in DW; lsu_wmask in DW/8; lsu_resp_valid out 1; lsu_rdata out DW.
REQ-006 Memory slave ports SHALL be: mem_req_valid out 1; mem_req_ready in 1; mem_addr out AW; mem_wen out 1; mem_wdata out DW; mem_wmask out DW/8; mem_resp_valid in 1; mem_rdata in DW.

Function
REQ-007 The FSM SHALL have states IDLE, REQ, RESP; at most one transaction outstanding.
REQ-008 In IDLE, *_req_ready SHALL be 1 only for the granted master; a handshake (valid&ready) latches addr/wen/wdata/wmask and owner, then moves to REQ.
REQ-009 If only one master is valid, it is granted; if both, grant goes to the master not granted last (last_owner register, reset value IFU, so the first tie goes to LSU).
REQ-010 IFU requests SHALL always latch wen=0 and wmask=0.
REQ-011 In REQ, mem_req_valid=1 with latched fields held stable until mem_req_ready=1; then move to RESP.
REQ-012 In RESP, when mem_resp_valid=1, assert the owner's *_resp_valid for that cycle with *_rdata=mem_rdata (combinational pass-through), update last_owner, and return to IDLE.
REQ-013 Minimum latency: accept in cycle N, mem_req_valid in N+1; with mem_req_ready=1 in N+1 and mem_resp_valid=1 in N+2, resp_valid in N+2; next accept is possible in N+3.
REQ-014 Both *_req_ready SHALL be 0 in REQ and RESP; no new request is accepted in the same cycle a response completes.
REQ-015 ifu_flush=1 while owner=IFU in REQ or RESP SHALL set a drop flag; the memory transaction still completes, but ifu_resp_valid stays 0 for it. The flag clears on return to IDLE.
REQ-016 ifu_flush in IDLE, or while owner=LSU, SHALL have no effect; ifu_flush in the same cycle as an IFU accept SHALL not cancel that accept.
REQ-017 ifu_resp_valid and lsu_resp_valid SHALL never both be 1; mem_resp_valid in IDLE or REQ is ignored.
REQ-018 *_rdata SHALL equal mem_rdata at all times; it is only meaningful with *_resp_valid.

Reset
REQ-019 rst=1 SHALL immediately force state=IDLE, last_owner=IFU, drop=0, and all latched fields to 0.
REQ-020 Under reset, all valid/ready outputs SHALL be 0, and mem_addr/mem_wdata/mem_wmask/mem_wen SHALL be 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it; a late mem_resp_valid after reset release while in IDLE is ignored.

Verification
REQ-022 IFU only: ifu_addr=0x80000000, ready memory with 1-cycle response rdata=0x00000413 -> mem_addr=0x80000000, mem_wen=0; ifu_resp_valid in cycle N+2 with rdata 0x00000413.
REQ-023 Tie: both valid in IDLE after reset -> LSU granted first; with both held valid, the next grant goes to IFU, then alternates.
REQ-024 LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF; mem_req_ready low for 3 cycles -> mem_req_valid held with stable fields for 4 cycles; lsu_resp_valid pulses once.
REQ-025 Flush: IFU fetch in RESP, ifu_flush=1 one cycle before mem_resp_valid -> ifu_resp_valid stays 0; next IFU request is accepted in the following IDLE.
REQ-026 Async reset asserted in RESP between clock edges -> outputs 0 without waiting for a clk edge; after release, a stray mem_resp_valid produces no resp_valid.
REQ-027 Random two-master traffic against a scoreboard -> every accepted non-flushed request gets exactly one response to the correct master, and responses never overlap.
